// File: rtl/ram_32_reader.sv
// ram_32_reader: snapshots a 32-entry complex sample buffer in one
// cycle and streams it out one word per valid/ready transfer.
//
// Ports:
//   clk, rst       clock, async active-high reset
//   load           capture request, honoured only while idle
//   in_re, in_im   flattened buffer, word k at [k*WORD_SIZE +: WORD_SIZE]
//   out_ready      consumer accepts the current word
//   out_valid      out_re/out_im/out_addr hold a word
//   out_re/out_im  current word (unmodified sample)
//   out_addr       buffer address of the current word
//   out_last       high with the 32nd word of the frame
//   busy           frame captured and not yet fully transferred
//   done           one-cycle pulse after the last transfer
module ram_32_reader #(
  parameter int WORD_SIZE   = 16,
  parameter bit BIT_REVERSE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [32*WORD_SIZE-1:0] in_re,
  input  logic [32*WORD_SIZE-1:0] in_im,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [WORD_SIZE-1:0]    out_re,
  output logic [WORD_SIZE-1:0]    out_im,
  output logic [4:0]              out_addr,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int BW = 32 * WORD_SIZE;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           count_q, count_d;
  logic [BW-1:0]        snap_re_q, snap_re_d;
  logic [BW-1:0]        snap_im_q, snap_im_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  logic [WORD_SIZE-1:0] out_re_q, out_re_d;
  logic [WORD_SIZE-1:0] out_im_q, out_im_d;
  logic [4:0]           out_addr_q, out_addr_d;

  logic                 xfer;
  logic [4:0]           next_cnt;
  logic [4:0]           next_addr;
  logic [4:0]           first_addr;

  function automatic logic [4:0] addr_of(
    input logic [4:0] c
  );
    if (BIT_REVERSE)
      return {c[0], c[1], c[2], c[3], c[4]};
    else
      return c;
  endfunction

  assign xfer       = out_valid_q & out_ready;
  assign next_cnt   = count_q + 5'd1;
  assign next_addr  = addr_of(next_cnt);
  assign first_addr = addr_of(5'd0);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    snap_re_d   = snap_re_q;
    snap_im_d   = snap_im_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          snap_re_d   = in_re;
          snap_im_d   = in_im;
          count_d     = 5'd0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_addr_d  = first_addr;
          // storage is written on this same edge, so the first
          // word is taken straight from the inputs
          out_re_d    = in_re[int'(first_addr)*WORD_SIZE +: WORD_SIZE];
          out_im_d    = in_im[int'(first_addr)*WORD_SIZE +: WORD_SIZE];
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (count_q == 5'd31) begin
            state_d     = IDLE;
            count_d     = 5'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            count_d     = next_cnt;
            out_addr_d  = next_addr;
            out_re_d    = snap_re_q[int'(next_addr)*WORD_SIZE +: WORD_SIZE];
            out_im_d    = snap_im_q[int'(next_addr)*WORD_SIZE +: WORD_SIZE];
            out_last_d  = (next_cnt == 5'd31);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= 5'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_addr_q  <= 5'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_addr_q  <= out_addr_d;
    end
  end

  // snapshot storage carries no reset; it is only read while streaming
  always_ff @(posedge clk) begin
    snap_re_q <= snap_re_d;
    snap_im_q <= snap_im_d;
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == STREAM);
  assign done      = done_q;

endmodule

// File: tb/tb_ram_32_reader.sv
// tb_ram_32_reader: drives a natural-order and a bit-reversed reader
// from the same stimulus and checks both against a frame model.
module tb_ram_32_reader;

  localparam int W = 16;

  logic            clk;
  logic            rst;
  logic            load;
  logic [32*W-1:0] in_re;
  logic [32*W-1:0] in_im;
  logic            out_ready;

  logic            n_valid, n_last, n_busy, n_done;
  logic [W-1:0]    n_re, n_im;
  logic [4:0]      n_addr;
  logic            b_valid, b_last, b_busy, b_done;
  logic [W-1:0]    b_re, b_im;
  logic [4:0]      b_addr;

  int tests;
  int fails;

  logic [W-1:0] sn_re [32];
  logic [W-1:0] sn_im [32];

  ram_32_reader #(.WORD_SIZE(W), .BIT_REVERSE(1'b0)) u_nat (
    .clk(clk), .rst(rst), .load(load),
    .in_re(in_re), .in_im(in_im), .out_ready(out_ready),
    .out_valid(n_valid), .out_re(n_re), .out_im(n_im),
    .out_addr(n_addr), .out_last(n_last),
    .busy(n_busy), .done(n_done)
  );

  ram_32_reader #(.WORD_SIZE(W), .BIT_REVERSE(1'b1)) u_rev (
    .clk(clk), .rst(rst), .load(load),
    .in_re(in_re), .in_im(in_im), .out_ready(out_ready),
    .out_valid(b_valid), .out_re(b_re), .out_im(b_im),
    .out_addr(b_addr), .out_last(b_last),
    .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // address of the k-th streamed word
  function automatic int exp_addr(input int k, input bit br);
    int r;
    if (!br) return k;
    r = 0;
    for (int i = 0; i < 5; i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 32; k++) begin
      in_re[k*W +: W] = 16'(16'h0100 + k);
      in_im[k*W +: W] = 16'(16'h0200 + k);
    end
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 32; k++) begin
      in_re[k*W +: W] = 16'($urandom);
      in_im[k*W +: W] = 16'($urandom);
    end
  endtask

  task automatic snap_inputs();
    for (int k = 0; k < 32; k++) begin
      sn_re[k] = in_re[k*W +: W];
      sn_im[k] = in_im[k*W +: W];
    end
  endtask

  task automatic test_reset();
    tests++;
    if (n_valid !== 1'b0 || n_last !== 1'b0 || n_busy !== 1'b0 ||
        n_done !== 1'b0 || n_re !== '0 || n_im !== '0 ||
        n_addr !== 5'd0) begin
      fails++;
      $display("FAIL reset_nat v=%0b l=%0b b=%0b d=%0b re=%h im=%h a=%0d req all 0",
               n_valid, n_last, n_busy, n_done, n_re, n_im, n_addr);
    end
    tests++;
    if (b_valid !== 1'b0 || b_last !== 1'b0 || b_busy !== 1'b0 ||
        b_done !== 1'b0 || b_re !== '0 || b_im !== '0 ||
        b_addr !== 5'd0) begin
      fails++;
      $display("FAIL reset_rev v=%0b l=%0b b=%0b d=%0b re=%h im=%h a=%0d req all 0",
               b_valid, b_last, b_busy, b_done, b_re, b_im, b_addr);
    end
  endtask

  task automatic test_stream();
    int ea, eb;
    fill_ramp();
    snap_inputs();
    out_ready = 1'b1;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 32; k++) begin
      ea = exp_addr(k, 1'b0);
      eb = exp_addr(k, 1'b1);
      tests++;
      if (n_valid !== 1'b1 || n_addr !== 5'(ea) || n_re !== sn_re[ea] ||
          n_im !== sn_im[ea] || n_last !== 1'(k == 31) ||
          n_busy !== 1'b1 || n_done !== 1'b0) begin
        fails++;
        $display("FAIL stream_nat k=%0d v=%0b a=%0d re=%h im=%h l=%0b d=%0b req a=%0d re=%h im=%h",
                 k, n_valid, n_addr, n_re, n_im, n_last, n_done, ea, sn_re[ea], sn_im[ea]);
      end
      tests++;
      if (b_valid !== 1'b1 || b_addr !== 5'(eb) || b_re !== sn_re[eb] ||
          b_im !== sn_im[eb] || b_last !== 1'(k == 31) ||
          b_busy !== 1'b1 || b_done !== 1'b0) begin
        fails++;
        $display("FAIL stream_rev k=%0d v=%0b a=%0d re=%h im=%h l=%0b d=%0b req a=%0d re=%h im=%h",
                 k, b_valid, b_addr, b_re, b_im, b_last, b_done, eb, sn_re[eb], sn_im[eb]);
      end
      tick();
    end
    tests++;
    if (n_done !== 1'b1 || n_busy !== 1'b0 || n_valid !== 1'b0 || n_last !== 1'b0 ||
        b_done !== 1'b1 || b_busy !== 1'b0 || b_valid !== 1'b0 || b_last !== 1'b0) begin
      fails++;
      $display("FAIL stream_done n:d=%0b b=%0b v=%0b r:d=%0b b=%0b v=%0b req d=1 b=0 v=0",
               n_done, n_busy, n_valid, b_done, b_busy, b_valid);
    end
    tick();
    tests++;
    if (n_done !== 1'b0 || b_done !== 1'b0 || n_busy !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse n=%0b r=%0b busy=%0b req 0", n_done, b_done, n_busy);
    end
  endtask

  // ready 1,0,0,1; inputs change every cycle; load retried at count 10
  task automatic test_backpressure();
    int k, cyc, ea, eb;
    bit rdy;
    fill_rand();
    snap_inputs();
    out_ready = 1'b0;
    load = 1'b1;
    tick();
    load = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 32 && cyc < 200) begin
      ea = exp_addr(k, 1'b0);
      eb = exp_addr(k, 1'b1);
      tests++;
      if (n_valid !== 1'b1 || n_addr !== 5'(ea) || n_re !== sn_re[ea] ||
          n_im !== sn_im[ea] || n_last !== 1'(k == 31) || n_done !== 1'b0) begin
        fails++;
        $display("FAIL bp_nat k=%0d v=%0b a=%0d re=%h im=%h l=%0b req a=%0d re=%h im=%h",
                 k, n_valid, n_addr, n_re, n_im, n_last, ea, sn_re[ea], sn_im[ea]);
      end
      tests++;
      if (b_valid !== 1'b1 || b_addr !== 5'(eb) || b_re !== sn_re[eb] ||
          b_im !== sn_im[eb] || b_last !== 1'(k == 31) || b_done !== 1'b0) begin
        fails++;
        $display("FAIL bp_rev k=%0d v=%0b a=%0d re=%h im=%h l=%0b req a=%0d re=%h im=%h",
                 k, b_valid, b_addr, b_re, b_im, b_last, eb, sn_re[eb], sn_im[eb]);
      end
      rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      out_ready = rdy;
      load = (k == 10);
      fill_rand();
      @(posedge clk);
      if (rdy) k++;
      @(negedge clk);
      cyc++;
    end
    load = 1'b0;
    tests++;
    if (k != 32) begin
      fails++;
      $display("FAIL bp_count transfers=%0d req 32", k);
    end
    tests++;
    if (n_done !== 1'b1 || n_valid !== 1'b0 || b_done !== 1'b1 || b_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_done n:d=%0b v=%0b r:d=%0b v=%0b req d=1 v=0",
               n_done, n_valid, b_done, b_valid);
    end
    out_ready = 1'b1;
    tick();
  endtask

  // load in the final-transfer cycle is dropped, load in done is taken
  task automatic test_final_load();
    int ea, eb;
    fill_rand();
    snap_inputs();
    out_ready = 1'b1;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k == 31) begin
        fill_rand();
        load = 1'b1;
      end
      tick();
    end
    tests++;
    if (n_done !== 1'b1 || n_busy !== 1'b0 || n_valid !== 1'b0 ||
        b_done !== 1'b1 || b_busy !== 1'b0 || b_valid !== 1'b0) begin
      fails++;
      $display("FAIL final_load n:d=%0b b=%0b v=%0b r:d=%0b b=%0b v=%0b req d=1 b=0 v=0",
               n_done, n_busy, n_valid, b_done, b_busy, b_valid);
    end
    fill_rand();
    snap_inputs();
    tick();
    load = 1'b0;
    for (int k = 0; k < 32; k++) begin
      ea = exp_addr(k, 1'b0);
      eb = exp_addr(k, 1'b1);
      tests++;
      if (n_valid !== 1'b1 || n_busy !== 1'b1 || n_addr !== 5'(ea) ||
          n_re !== sn_re[ea] || n_im !== sn_im[ea] ||
          b_valid !== 1'b1 || b_addr !== 5'(eb) ||
          b_re !== sn_re[eb] || b_im !== sn_im[eb]) begin
        fails++;
        $display("FAIL done_load k=%0d n:a=%0d re=%h r:a=%0d re=%h req n:a=%0d re=%h r:a=%0d re=%h",
                 k, n_addr, n_re, b_addr, b_re, ea, sn_re[ea], eb, sn_re[eb]);
      end
      tick();
    end
    tests++;
    if (n_done !== 1'b1 || b_done !== 1'b1) begin
      fails++;
      $display("FAIL done_load_end n=%0b r=%0b req 1", n_done, b_done);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int k, ea;
    bit seen_done;
    fill_rand();
    snap_inputs();
    out_ready = 1'b1;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    tests++;
    if (n_addr !== 5'd17 || b_addr !== 5'(exp_addr(17, 1'b1))) begin
      fails++;
      $display("FAIL pre_rst n:a=%0d r:a=%0d req 17 %0d", n_addr, b_addr, exp_addr(17, 1'b1));
    end
    rst = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    tests++;
    if (n_done !== 1'b0 || b_done !== 1'b0 || n_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_no_done n=%0b r=%0b v=%0b req 0", n_done, b_done, n_valid);
    end
    rst = 1'b0;
    tick();
    fill_rand();
    snap_inputs();
    load = 1'b1;
    tick();
    load = 1'b0;
    k = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (n_done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        ea = exp_addr(k, 1'b0);
        tests++;
        if (n_valid !== 1'b1 || n_addr !== 5'(ea) || n_re !== sn_re[ea] ||
            b_addr !== 5'(exp_addr(k, 1'b1))) begin
          fails++;
          $display("FAIL post_rst k=%0d v=%0b a=%0d re=%h ra=%0d req a=%0d re=%h",
                   k, n_valid, n_addr, n_re, b_addr, ea, sn_re[ea]);
        end
        k++;
        tick();
      end
    end
    tests++;
    if (!seen_done || k != 32) begin
      fails++;
      $display("FAIL post_rst_frame words=%0d done=%0b req 32 1", k, seen_done);
    end
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    load = 1'b0;
    out_ready = 1'b0;
    in_re = '0;
    in_im = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_final_load();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
